// File: rtl/am9513_pkg.sv
// am9513_pkg: Am9511 front-end command codes, status byte layout and FSM states.
package am9513_pkg;
   localparam logic [6:0] CMD_NOP  = 7'h00;
   localparam logic [6:0] CMD_SQRT = 7'h01;
   localparam logic [6:0] CMD_SIN  = 7'h02;
   localparam logic [6:0] CMD_ADD  = 7'h10;
   localparam logic [6:0] CMD_SUB  = 7'h11;
   localparam logic [6:0] CMD_MUL  = 7'h12;
   localparam logic [6:0] CMD_DIV  = 7'h13;
   localparam logic [6:0] CMD_FMA  = 7'h14;
   localparam int ST_BUSY = 7;
   localparam int ST_SIGN = 6;
   localparam int ST_ZERO = 5;
   localparam int ST_CODE = 1;
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WRBK} state_e;
endpackage

// File: rtl/carbon_pkg.sv
// carbon_pkg: shared executor function, format and status codes used by the
// front end and the arithmetic executor it talks to.
package carbon_pkg;
   localparam logic [7:0]  CARBON_FUNC_ADD          = 8'h01;
   localparam logic [7:0]  CARBON_FUNC_SUB          = 8'h02;
   localparam logic [7:0]  CARBON_FUNC_MUL          = 8'h03;
   localparam logic [7:0]  CARBON_FUNC_DIV          = 8'h04;
   localparam logic [7:0]  CARBON_FUNC_SQRT         = 8'h05;
   localparam logic [7:0]  CARBON_FUNC_SIN          = 8'h06;
   localparam logic [7:0]  CARBON_FUNC_FMA          = 8'h07;
   localparam logic [7:0]  CARBON_FMT_BINARY32      = 8'h02;
   localparam logic [15:0] CARBON_STATUS_OK         = 16'h0000;
   localparam logic [15:0] CARBON_STATUS_INVALID_OP = 16'h0005;
endpackage

// File: rtl/am9511_byte_stack.sv
// am9511_byte_stack: 16-byte circular stack with little-endian TOS/NOS/third
// word views and a single-cycle "pop N words, push one word" writeback.
module am9511_byte_stack (
   input  logic        clk,
   input  logic        rst,
   input  logic        push_i,
   input  logic        pop_i,
   input  logic [7:0]  din_i,
   input  logic        wb_i,
   input  logic [1:0]  wb_pop_i,
   input  logic [31:0] wb_word_i,
   output logic [7:0]  dout_o,
   output logic [31:0] tos_o,
   output logic [31:0] nos_o,
   output logic [31:0] third_o
);
   logic [7:0] mem_q [16];
   logic [3:0] ptr_q;
   logic [3:0] base;

   assign base   = ptr_q - {wb_pop_i, 2'b00};
   assign dout_o = mem_q[ptr_q - 4'd1];

   // the lowest-addressed byte of each word is its LSB (first pushed)
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         tos_o[8*i +: 8]   = mem_q[ptr_q - 4'd4 + 4'(i)];
         nos_o[8*i +: 8]   = mem_q[ptr_q - 4'd8 + 4'(i)];
         third_o[8*i +: 8] = mem_q[ptr_q - 4'd12 + 4'(i)];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
         for (int i = 0; i < 16; i++) mem_q[i] <= '0;
      end else if (wb_i) begin
         for (int i = 0; i < 4; i++) mem_q[base + 4'(i)] <= wb_word_i[8*i +: 8];
         ptr_q <= base + 4'd4;
      end else if (push_i) begin
         mem_q[ptr_q] <= din_i;
         ptr_q <= ptr_q + 4'd1;
      end else if (pop_i) begin
         ptr_q <= ptr_q - 4'd1;
      end
   end
endmodule

// File: rtl/am9511_bus_frontend.sv
// am9511_bus_frontend: Am9511-style byte bus front end feeding a 64-bit executor.
// Define AM9511_FRONTEND_FMA_EN to decode command 0x14 as a three-operand FMA.
module am9511_bus_frontend
   import carbon_pkg::*;
   import am9513_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        bus_wr,
   input  logic        bus_rd,
   input  logic        bus_cd,
   input  logic [7:0]  bus_wdata,
   output logic [7:0]  bus_rdata,
   output logic        bus_rvalid,
   output logic        req_valid,
   input  logic        req_ready,
   output logic [7:0]  req_func,
   output logic [7:0]  req_fmt,
   output logic [31:0] req_flags,
   output logic [63:0] req_op0,
   output logic [63:0] req_op1,
   output logic [63:0] req_op2,
   output logic [1:0]  req_rm,
   input  logic        rsp_valid,
   input  logic [63:0] rsp_value,
   input  logic [15:0] rsp_status,
   output logic        busy,
   output logic        irq
);
   state_e      state_q, state_d;
   logic [7:0]  func_q, func_d, rdata_q, rdata_d, dout, dec_func, status;
   logic [63:0] op0_q, op0_d, op1_q, op1_d, op2_q, op2_d;
   logic [1:0]  npop_q, npop_d, dec_n;
   logic [31:0] res_q, res_d, tos, nos, third;
   logic [15:0] rstat_q, rstat_d;
   logic [3:0]  code_q, code_d;
   logic        sre_q, sre_d, irq_q, irq_d, sign_q, sign_d, zero_q, zero_d, rvalid_q;
   logic        dec_ok, idle, wr, rd, cmd_wr, wb_ok, unused_hi;

   assign wr        = bus_wr & ~bus_rd;
   assign rd        = bus_rd & ~bus_wr;
   assign idle      = state_q == S_IDLE;
   assign cmd_wr    = wr & bus_cd & idle;
   assign wb_ok     = (state_q == S_WRBK) && (rstat_q == CARBON_STATUS_OK);
   assign unused_hi = ^rsp_value[63:32];

   am9511_byte_stack u_stack (
      .clk(clk), .rst(rst),
      .push_i(wr & ~bus_cd & idle), .pop_i(rd & ~bus_cd & idle), .din_i(bus_wdata),
      .wb_i(wb_ok), .wb_pop_i(npop_q), .wb_word_i(res_q),
      .dout_o(dout), .tos_o(tos), .nos_o(nos), .third_o(third)
   );

   always_comb begin
      status = '0;
      status[ST_BUSY] = ~idle;
      status[ST_SIGN] = sign_q;
      status[ST_ZERO] = zero_q;
      status[ST_CODE +: 4] = code_q;
   end

   always_comb begin
      dec_ok = 1'b1;
      dec_n = 2'd2;
      dec_func = CARBON_FUNC_ADD;
      case (bus_wdata[6:0])
         CMD_ADD:  dec_func = CARBON_FUNC_ADD;
         CMD_SUB:  dec_func = CARBON_FUNC_SUB;
         CMD_MUL:  dec_func = CARBON_FUNC_MUL;
         CMD_DIV:  dec_func = CARBON_FUNC_DIV;
         CMD_SQRT: begin dec_func = CARBON_FUNC_SQRT; dec_n = 2'd1; end
         CMD_SIN:  begin dec_func = CARBON_FUNC_SIN; dec_n = 2'd1; end
`ifdef AM9511_FRONTEND_FMA_EN
         CMD_FMA:  begin dec_func = CARBON_FUNC_FMA; dec_n = 2'd3; end
`else
         CMD_FMA:  dec_ok = 1'b0;
`endif
         default:  dec_ok = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      func_d = func_q;
      op0_d = op0_q;
      op1_d = op1_q;
      op2_d = op2_q;
      npop_d = npop_q;
      sre_d = sre_q;
      irq_d = irq_q;
      res_d = res_q;
      rstat_d = rstat_q;
      sign_d = sign_q;
      zero_d = zero_q;
      code_d = code_q;
      rdata_d = rd ? (bus_cd ? status : (idle ? dout : 8'hFF)) : rdata_q;
      if (rd && bus_cd) irq_d = 1'b0;
      case (state_q)
         S_IDLE: if (cmd_wr) begin
            // NOP and undefined commands complete here, so SRE raises irq at once
            sre_d = bus_wdata[7];
            irq_d = ~dec_ok & bus_wdata[7];
            func_d = dec_func;
            npop_d = dec_n;
            op0_d = {32'd0, dec_n == 2'd1 ? tos : (dec_n == 2'd2 ? nos : third)};
            op1_d = {32'd0, dec_n == 2'd2 ? tos : (dec_n == 2'd3 ? nos : 32'd0)};
            op2_d = {32'd0, dec_n == 2'd3 ? tos : 32'd0};
            if (dec_ok) state_d = S_ISSUE;
            else if (bus_wdata[6:0] != CMD_NOP) code_d = CARBON_STATUS_INVALID_OP[3:0];
         end
         S_ISSUE: if (req_ready) state_d = S_WAIT;
         S_WAIT: if (rsp_valid) begin
            state_d = S_WRBK;
            res_d = rsp_value[31:0];
            rstat_d = rsp_status;
         end
         default: begin
            state_d = S_IDLE;
            code_d = rstat_q[3:0];
            if (wb_ok) begin
               sign_d = res_q[31];
               zero_d = res_q == 32'd0;
            end
            if (sre_q) irq_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         func_q <= '0;
         op0_q <= '0;
         op1_q <= '0;
         op2_q <= '0;
         npop_q <= '0;
         sre_q <= 1'b0;
         irq_q <= 1'b0;
         res_q <= '0;
         rstat_q <= '0;
         sign_q <= 1'b0;
         zero_q <= 1'b0;
         code_q <= '0;
         rdata_q <= '0;
         rvalid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         func_q <= func_d;
         op0_q <= op0_d;
         op1_q <= op1_d;
         op2_q <= op2_d;
         npop_q <= npop_d;
         sre_q <= sre_d;
         irq_q <= irq_d;
         res_q <= res_d;
         rstat_q <= rstat_d;
         sign_q <= sign_d;
         zero_q <= zero_d;
         code_q <= code_d;
         rdata_q <= rdata_d;
         rvalid_q <= rd;
      end
   end

   assign bus_rdata  = rdata_q;
   assign bus_rvalid = rvalid_q;
   assign req_valid  = state_q == S_ISSUE;
   assign req_func   = func_q;
   assign req_fmt    = CARBON_FMT_BINARY32;
   assign req_flags  = '0;
   assign req_op0    = op0_q;
   assign req_op1    = op1_q;
   assign req_op2    = op2_q;
   assign req_rm     = '0;
   assign busy       = ~idle;
   assign irq        = irq_q;
endmodule
